// File: rtl/dll_tx_fc_dllp_gen.sv
// Round-robin InitFC1/InitFC2/UpdateFC DLLP generator with coalescing per-channel credit requests.
// Build option DLL_DLLP_CRC_EN: real DLLP CRC-16 in [47:32]; otherwise the field is 16'hBEEF.
module dll_tx_fc_dllp_gen #(
  parameter int         NUM_CH = 3,
  parameter logic [2:0] VC_ID  = 3'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           dlc_state_i,
  input  logic [1:0]           fc_mode_i,
  input  logic [NUM_CH-1:0]    update_req_i,
  input  logic [NUM_CH*8-1:0]  hdr_credit_i,
  input  logic [NUM_CH*12-1:0] data_credit_i,
  input  logic                 dllp_ready_i,
  output logic [47:0]          dllp_o,
  output logic                 dllp_valid_o,
  output logic [NUM_CH-1:0]    pending_o
);
  typedef enum logic [1:0] {ST_IDLE, ST_BUILD, ST_HOLD} state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]        hdr_snap_q  [NUM_CH];
  logic [11:0]       data_snap_q [NUM_CH];
  logic [7:0]        win_hdr_q;
  logic [11:0]       win_data_q;
  logic [1:0]        win_ch_q, win_mode_q;
  logic [47:0]       dllp_q, dllp_d;
  logic              valid_q, valid_d;

  logic              link_down, eligible, grant_found, do_grant;
  logic [1:0]        grant_idx;
  logic [2:0]        cand;
  logic [3:0]        pend_ext;
  logic [1:0]        type_pfx;
  logic [31:0]       body;
  logic [47:0]       dllp_built;

  assign link_down = (dlc_state_i == 2'b00);
  assign eligible  = ((fc_mode_i == 2'b00 || fc_mode_i == 2'b01) && dlc_state_i == 2'b10) ||
                     (fc_mode_i == 2'b10 && dlc_state_i == 2'b11);
  assign pend_ext  = 4'(pending_q);

  // First pending channel at or after rr_ptr; scanning downward lets the nearest one win.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    cand        = 3'd0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + 3'(k);
      if (cand >= 3'(NUM_CH)) cand = cand - 3'(NUM_CH);
      if (pend_ext[cand[1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[1:0];
      end
    end
  end

  assign do_grant = (state_q == ST_IDLE) && !link_down && eligible && grant_found;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (do_grant) rr_ptr_d = (grant_idx == 2'(NUM_CH - 1)) ? 2'd0 : grant_idx + 2'd1;
  end

  // A fresh request outranks the clear from a same-cycle grant.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (link_down)                           pending_d[i] = 1'b0;
      else if (update_req_i[i])                pending_d[i] = 1'b1;
      else if (do_grant && grant_idx == 2'(i)) pending_d[i] = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_snap
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hdr_snap_q[gi]  <= '0;
        data_snap_q[gi] <= '0;
      end else if (update_req_i[gi] && !link_down) begin
        hdr_snap_q[gi]  <= hdr_credit_i[8*gi +: 8];
        data_snap_q[gi] <= data_credit_i[12*gi +: 12];
      end
    end
  end

  always_comb begin
    case (win_mode_q)
      2'b00:   type_pfx = 2'b01;
      2'b01:   type_pfx = 2'b11;
      default: type_pfx = 2'b10;
    endcase
  end

  assign body = {win_data_q[7:0],
                 win_hdr_q[1:0], 2'b00, win_data_q[11:8],
                 2'b00, win_hdr_q[7:2],
                 type_pfx, win_ch_q, 1'b0, VC_ID};

`ifdef DLL_DLLP_CRC_EN
  // Bit-serial LFSR, byte 0 bit 0 first; result complemented and each byte bit-reversed.
  function automatic logic [15:0] dllp_crc(input logic [31:0] msg);
    logic [15:0] c;
    logic [15:0] r;
    c = 16'hFFFF;
    for (int b = 0; b < 32; b++) begin
      if (c[15] ^ msg[b]) c = {c[14:0], 1'b0} ^ 16'h100B;
      else                c = {c[14:0], 1'b0};
    end
    c = ~c;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      r[8 + j] = c[7 - j];
      r[j]     = c[15 - j];
    end
    return r;
  endfunction

  assign dllp_built = {dllp_crc(body), body};
`else
  assign dllp_built = {16'hBEEF, body};
`endif

  always_comb begin
    state_d = state_q;
    dllp_d  = dllp_q;
    valid_d = valid_q;
    if (link_down) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:  if (do_grant) state_d = ST_BUILD;
        ST_BUILD: begin
          dllp_d  = dllp_built;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
        ST_HOLD:  if (dllp_ready_i) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      rr_ptr_q   <= 2'd0;
      win_hdr_q  <= '0;
      win_data_q <= '0;
      win_ch_q   <= 2'd0;
      win_mode_q <= 2'd0;
      dllp_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      dllp_q    <= dllp_d;
      valid_q   <= valid_d;
      if (do_grant) begin
        win_hdr_q  <= hdr_snap_q[grant_idx];
        win_data_q <= data_snap_q[grant_idx];
        win_ch_q   <= grant_idx;
        win_mode_q <= fc_mode_i;
      end
    end
  end

  assign dllp_o       = dllp_q;
  assign dllp_valid_o = valid_q;
  assign pending_o    = pending_q;

endmodule

// File: tb/tb_dll_tx_fc_dllp_gen.sv
// Self-checking bench for dll_tx_fc_dllp_gen: field-level DLLP model, rotating-priority order model.
module tb_dll_tx_fc_dllp_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  dlc_state_i = 2'b11;
  logic [1:0]  fc_mode_i = 2'b10;
  logic [2:0]  update_req_i = 3'b000;
  logic [23:0] hdr_credit_i = '0;
  logic [35:0] data_credit_i = '0;
  logic        dllp_ready_i = 1'b1;
  logic [47:0] dllp_o;
  logic        dllp_valid_o;
  logic [2:0]  pending_o;

  dll_tx_fc_dllp_gen #(.NUM_CH(3), .VC_ID(3'd0)) dut (
    .clk(clk), .rst_n(rst_n), .dlc_state_i(dlc_state_i), .fc_mode_i(fc_mode_i),
    .update_req_i(update_req_i), .hdr_credit_i(hdr_credit_i), .data_credit_i(data_credit_i),
    .dllp_ready_i(dllp_ready_i), .dllp_o(dllp_o), .dllp_valid_o(dllp_valid_o), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rr_model = 0;
  logic [7:0]  exp_hdr [3];
  logic [11:0] exp_data [3];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [15:0] crc_model(input logic [31:0] msg);
    logic [15:0] c;
    logic [15:0] r;
    logic [15:0] o;
    logic [7:0]  byt;
    c = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      byt = msg[8*i +: 8];
      for (int j = 0; j < 8; j++) begin
        if (c[15] ^ byt[j]) c = (c << 1) ^ 16'h100B;
        else                c = c << 1;
      end
    end
    r = ~c;
    o = '0;
    for (int j = 0; j < 8; j++) begin
      o[8 + j] = r[7 - j];
      o[j]     = r[15 - j];
    end
    return o;
  endfunction

  function automatic logic [47:0] make_dllp(input logic [3:0] typ, input logic [7:0] h,
                                            input logic [11:0] d);
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] msg;
    b0 = {typ, 1'b0, 3'b000};
    b1 = {2'b00, h[7:2]};
    b2 = {h[1:0], 2'b00, d[11:8]};
    b3 = d[7:0];
    msg = {b3, b2, b1, b0};
`ifdef DLL_DLLP_CRC_EN
    return {crc_model(msg), msg};
`else
    return {16'hBEEF, msg};
`endif
  endfunction

  // Random credits on every lane; the model remembers what each requested channel latched.
  task automatic drive_req(input logic [2:0] mask);
    for (int c = 0; c < 3; c++) begin
      hdr_credit_i[8*c +: 8]    = 8'($urandom);
      data_credit_i[12*c +: 12] = 12'($urandom);
      if (mask[c]) begin
        exp_hdr[c]  = hdr_credit_i[8*c +: 8];
        exp_data[c] = data_credit_i[12*c +: 12];
      end
    end
    update_req_i = mask;
  endtask

  task automatic wait_beat(output bit ok);
    int n;
    n = 0;
    while (!dllp_valid_o && n < 20) begin
      tick();
      n++;
    end
    ok = dllp_valid_o;
  endtask

  task automatic test_reset();
    #2;
    total++; if (dllp_o !== 48'h0) begin bad++; $display("FAIL reset_dllp got=%h want=0", dllp_o); end
    total++; if (dllp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", dllp_valid_o); end
    total++; if (pending_o !== 3'b000) begin bad++; $display("FAIL reset_pending got=%b want=000", pending_o); end
    tick();
    rst_n = 1'b1;
    tick();
    rr_model = 0;
  endtask

  task automatic test_round_robin();
    logic [2:0] masks [2];
    int exp_ch [$];
    int last_cyc;
    bit ok;
    masks[0] = 3'b111;
    masks[1] = 3'b101;
    for (int m = 0; m < 2; m++) begin
      exp_ch = {};
      for (int k = 0; k < 3; k++) if (masks[m][(rr_model + k) % 3]) exp_ch.push_back((rr_model + k) % 3);
      rr_model = (exp_ch[$] + 1) % 3;
      drive_req(masks[m]);
      tick();
      update_req_i = '0;
      last_cyc = -1;
      foreach (exp_ch[i]) begin
        wait_beat(ok);
        total++;
        if (!ok || dllp_o !== make_dllp({2'b10, 2'(exp_ch[i])}, exp_hdr[exp_ch[i]], exp_data[exp_ch[i]])) begin
          bad++; $display("FAIL rr_beat set=%0d idx=%0d got=%h valid=%b want=%h", m, i, dllp_o, ok,
                          make_dllp({2'b10, 2'(exp_ch[i])}, exp_hdr[exp_ch[i]], exp_data[exp_ch[i]]));
        end
        if (last_cyc >= 0) begin
          total++;
          if (cyc - last_cyc != 3) begin bad++; $display("FAIL rr_spacing got=%0d want=3", cyc - last_cyc); end
        end
        last_cyc = cyc;
        tick();
      end
    end
  endtask

  task automatic test_single();
    logic [47:0] exp;
    hdr_credit_i[15:8]   = 8'hA5;
    data_credit_i[23:12] = 12'h3C7;
    update_req_i = 3'b010;
    exp = make_dllp(4'b1001, 8'hA5, 12'h3C7);
    tick();
    update_req_i = '0;
    total++; if (pending_o !== 3'b010) begin bad++; $display("FAIL single_pending got=%b want=010", pending_o); end
    tick();
    total++; if (dllp_valid_o !== 1'b0 || pending_o !== 3'b000) begin
      bad++; $display("FAIL single_grant valid=%b pending=%b want 0/000", dllp_valid_o, pending_o); end
    tick();
    total++; if (dllp_valid_o !== 1'b1 || dllp_o !== exp) begin
      bad++; $display("FAIL single_beat valid=%b got=%h want=%h", dllp_valid_o, dllp_o, exp); end
    tick();
    total++; if (dllp_valid_o !== 1'b0) begin bad++; $display("FAIL single_oneshot valid=%b want=0", dllp_valid_o); end
    rr_model = 2;
  endtask

  task automatic test_backpressure();
    logic [47:0] exp;
    bit ok;
    int ch;
    ch = (rr_model + 1) % 3;
    dllp_ready_i = 1'b0;
    drive_req(3'(1 << ch));
    exp = make_dllp({2'b10, 2'(ch)}, exp_hdr[ch], exp_data[ch]);
    tick();
    update_req_i = '0;
    rr_model = (ch + 1) % 3;
    wait_beat(ok);
    fc_mode_i = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (dllp_valid_o !== 1'b1 || dllp_o !== exp) begin
        bad++; $display("FAIL bp_hold cyc=%0d valid=%b got=%h want=%h", i, dllp_valid_o, dllp_o, exp); end
    end
    fc_mode_i = 2'b10;
    dllp_ready_i = 1'b1;
    tick();
    total++; if (dllp_valid_o !== 1'b0) begin bad++; $display("FAIL bp_release valid=%b want=0", dllp_valid_o); end
  endtask

  task automatic test_coalesce();
    bit ok;
    int seen;
    logic [47:0] exp;
    dllp_ready_i = 1'b0;
    drive_req(3'b010);
    tick();
    update_req_i = '0;
    wait_beat(ok);
    total++; if (!ok || dllp_o[7:4] !== 4'b1001) begin
      bad++; $display("FAIL co_first valid=%b type=%b want=1001", ok, dllp_o[7:4]); end
    drive_req(3'b001);
    hdr_credit_i[7:0] = 8'h10;
    tick();
    drive_req(3'b001);
    hdr_credit_i[7:0] = 8'h20;
    exp_hdr[0] = 8'h20;
    tick();
    update_req_i = '0;
    total++; if (pending_o !== 3'b001 || dllp_valid_o !== 1'b1) begin
      bad++; $display("FAIL co_pending pending=%b valid=%b want 001/1", pending_o, dllp_valid_o); end
    dllp_ready_i = 1'b1;
    tick();
    exp = make_dllp(4'b1000, 8'h20, exp_data[0]);
    wait_beat(ok);
    total++; if (!ok || dllp_o !== exp) begin
      bad++; $display("FAIL co_beat valid=%b got=%h want=%h", ok, dllp_o, exp); end
    tick();
    rr_model = 1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (dllp_valid_o) seen++;
      tick();
    end
    total++; if (seen != 0 || pending_o !== 3'b000) begin
      bad++; $display("FAIL co_once extra_beats=%0d pending=%b want 0/000", seen, pending_o); end
  endtask

  task automatic test_gating();
    bit ok;
    int seen;
    dllp_ready_i = 1'b0;
    fc_mode_i = 2'b00;
    drive_req(3'b001);
    tick();
    update_req_i = '0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (dllp_valid_o) seen++;
      tick();
    end
    total++; if (seen != 0 || pending_o[0] !== 1'b1) begin
      bad++; $display("FAIL gate_block beats=%0d pending0=%b want 0/1", seen, pending_o[0]); end
    dlc_state_i = 2'b10;
    wait_beat(ok);
    total++; if (!ok || dllp_o !== make_dllp(4'b0100, exp_hdr[0], exp_data[0])) begin
      bad++; $display("FAIL gate_initfc1 valid=%b got=%h want=%h", ok, dllp_o, make_dllp(4'b0100, exp_hdr[0], exp_data[0])); end
    drive_req(3'b010);
    tick();
    update_req_i = '0;
    total++; if (pending_o !== 3'b010 || dllp_valid_o !== 1'b1) begin
      bad++; $display("FAIL gate_hold pending=%b valid=%b want 010/1", pending_o, dllp_valid_o); end
    dlc_state_i = 2'b00;
    drive_req(3'b100);
    tick();
    update_req_i = '0;
    total++; if (dllp_valid_o !== 1'b0 || pending_o !== 3'b000) begin
      bad++; $display("FAIL gate_down valid=%b pending=%b want 0/000", dllp_valid_o, pending_o); end
    dlc_state_i = 2'b11;
    fc_mode_i = 2'b10;
    dllp_ready_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dllp_valid_o) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL gate_flushed beats=%0d want=0", seen); end
    rr_model = 1;
  endtask

  task automatic test_random();
    int nbeats;
    int target;
    int exp_ch [$];
    logic [2:0] mask;
    logic [47:0] exp;
    bit ok;
`ifdef DLL_DLLP_CRC_EN
    target = 200;
`else
    target = 40;
`endif
    nbeats = 0;
    while (nbeats < target) begin
      mask = 3'($urandom_range(1, 7));
      exp_ch = {};
      for (int k = 0; k < 3; k++) if (mask[(rr_model + k) % 3]) exp_ch.push_back((rr_model + k) % 3);
      rr_model = (exp_ch[$] + 1) % 3;
      drive_req(mask);
      tick();
      update_req_i = '0;
      foreach (exp_ch[i]) begin
        exp = make_dllp({2'b10, 2'(exp_ch[i])}, exp_hdr[exp_ch[i]], exp_data[exp_ch[i]]);
        wait_beat(ok);
        total++; if (!ok || dllp_o !== exp) begin
          bad++; $display("FAIL rand_beat n=%0d valid=%b got=%h want=%h", nbeats, ok, dllp_o, exp); end
        nbeats++;
        tick();
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    dllp_ready_i = 1'b0;
    drive_req(3'b011);
    tick();
    update_req_i = '0;
    wait_beat(ok);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (dllp_valid_o !== 1'b0 || dllp_o !== 48'h0 || pending_o !== 3'b000) begin
      bad++; $display("FAIL async_reset valid=%b dllp=%h pending=%b want 0/0/000", dllp_valid_o, dllp_o, pending_o); end
    tick();
    rst_n = 1'b1;
    dllp_ready_i = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_coalesce();
    test_gating();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
